window_frame_reader: RTL and testbench

//  Drains one windowed, zero-padded frame from the window memory and streams it to the FFT

---
 rtl/window_frame_reader.sv | 169 ++++++++++++++++
 tb/tb_window_frame_reader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/window_frame_reader.sv
// Streams one zero-padded window frame from window memory to the FFT input,
// in natural or bit-reversed read order, through a 4-entry fall-through FIFO.
module window_frame_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reader_en,
    input  logic [11:0]           fft_num,
    input  logic                  bitrev_en,
    output logic                  win_mem_rd_en,
    output logic [ADDR_WIDTH-1:0] win_mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] win_mem_rd_data,
    output logic                  fft_valid,
    input  logic                  fft_ready,
    output logic [DATA_WIDTH-1:0] fft_data,
    output logic [ADDR_WIDTH-1:0] fft_index,
    output logic                  fft_last,
    output logic                  reader_busy,
    output logic                  reader_done,
    output logic                  cfg_err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [11:0]             n_q, n_d;
    logic                    bitrev_q, bitrev_d;
    logic [ADDR_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic                    inflight_q, inflight_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [1:0]              wr_ptr_q, wr_ptr_d;
    logic [1:0]              rd_ptr_q, rd_ptr_d;
    logic                    cfg_err_q, cfg_err_d;
    logic [DATA_WIDTH-1:0]   fifo_q [4];

    logic                    num_legal;
    logic                    start;
    logic                    rd_en_int;
    logic                    valid_int;
    logic                    last_int;
    logic                    pop;
    logic                    push;
    logic                    rd_last;
    logic [ADDR_WIDTH-1:0]   n_m1;
    logic [3:0]              log2_n;
    logic [ADDR_WIDTH-1:0]   rev_full;
    logic [ADDR_WIDTH-1:0]   addr_int;
    int unsigned             rev_shift;

    assign num_legal = (fft_num >= 12'd8) && (fft_num <= 12'd2048)
                       && ((fft_num & (fft_num - 12'd1)) == '0);
    assign start     = (state_q == IDLE) && reader_en && num_legal;
    assign n_m1      = ADDR_WIDTH'(n_q - 12'd1);
    assign rd_last   = (rd_cnt_q == n_m1);
    assign push      = inflight_q;
    assign pop       = valid_int && fft_ready;

    // Credit counts buffered words plus the read already in flight; a pop in
    // the same cycle frees its slot only from the next cycle on.
    assign rd_en_int = (state_q == RUN) && (({1'b0, cnt_q} + 4'(inflight_q)) < 4'd4);
    assign valid_int = (cnt_q != 3'd0);
    assign last_int  = valid_int && (idx_q == n_m1);

    always_comb begin
        log2_n = '0;
        for (int unsigned i = 0; i < 12; i++) begin
            if (n_q[i]) log2_n = 4'(i);
        end
    end

    // Reverse the full counter, then shift the reversed bits down so only
    // the low log2(N) positions carry the reversed index.
    always_comb begin
        rev_full = '0;
        for (int unsigned i = 0; i < ADDR_WIDTH; i++) begin
            rev_full[i] = rd_cnt_q[ADDR_WIDTH-1-i];
        end
        rev_shift = ADDR_WIDTH - int'(log2_n);
        addr_int  = bitrev_q ? (rev_full >> rev_shift) : rd_cnt_q;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (rd_en_int && rd_last) state_d = DRAIN;
            DRAIN:   if (pop && last_int) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        win_mem_rd_en   = rd_en_int;
        win_mem_rd_addr = rd_en_int ? addr_int : '0;
        fft_valid       = valid_int;
        fft_data        = valid_int ? fifo_q[rd_ptr_q] : '0;
        fft_index       = valid_int ? idx_q : '0;
        fft_last        = last_int;
        reader_busy     = (state_q != IDLE) && (state_q != DONE);
        reader_done     = (state_q == DONE);
        cfg_err         = cfg_err_q;
    end

    // Datapath next values
    always_comb begin
        n_d        = n_q;
        bitrev_d   = bitrev_q;
        rd_cnt_d   = rd_cnt_q;
        idx_d      = idx_q;
        inflight_d = rd_en_int;
        cnt_d      = cnt_q + 3'(push) - 3'(pop);
        wr_ptr_d   = wr_ptr_q + 2'(push);
        rd_ptr_d   = rd_ptr_q + 2'(pop);
        cfg_err_d  = (state_q == IDLE) && reader_en && !num_legal;
        if (start) begin
            n_d      = fft_num;
            bitrev_d = bitrev_en;
            rd_cnt_d = '0;
            idx_d    = '0;
        end else begin
            if (rd_en_int) rd_cnt_d = rd_cnt_q + 1'b1;
            if (pop)       idx_d    = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q        <= '0;
            bitrev_q   <= 1'b0;
            rd_cnt_q   <= '0;
            idx_q      <= '0;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cfg_err_q  <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) fifo_q[i] <= '0;
        end else begin
            n_q        <= n_d;
            bitrev_q   <= bitrev_d;
            rd_cnt_q   <= rd_cnt_d;
            idx_q      <= idx_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cfg_err_q  <= cfg_err_d;
            if (push) fifo_q[wr_ptr_q] <= win_mem_rd_data;
        end
    end

endmodule

// File: tb/tb_window_frame_reader.sv
// Directed bench for window_frame_reader: latency, bit-reversal, backpressure,
// illegal lengths, DONE-cycle start and mid-frame reset.
module tb_window_frame_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reader_en = 1'b0;
    logic [11:0] fft_num = '0;
    logic        bitrev_en = 1'b0;
    logic        win_mem_rd_en;
    logic [11:0] win_mem_rd_addr;
    logic [31:0] win_mem_rd_data = '0;
    logic        fft_valid;
    logic        fft_ready = 1'b0;
    logic [31:0] fft_data;
    logic [11:0] fft_index;
    logic        fft_last;
    logic        reader_busy;
    logic        reader_done;
    logic        cfg_err;

    int checks = 0;
    int errors = 0;

    window_frame_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
        .clk             (clk),
        .rst             (rst),
        .reader_en       (reader_en),
        .fft_num         (fft_num),
        .bitrev_en       (bitrev_en),
        .win_mem_rd_en   (win_mem_rd_en),
        .win_mem_rd_addr (win_mem_rd_addr),
        .win_mem_rd_data (win_mem_rd_data),
        .fft_valid       (fft_valid),
        .fft_ready       (fft_ready),
        .fft_data        (fft_data),
        .fft_index       (fft_index),
        .fft_last        (fft_last),
        .reader_busy     (reader_busy),
        .reader_done     (reader_done),
        .cfg_err         (cfg_err)
    );

    always #5 clk = ~clk;

    // Window memory holds mem[a] = a, one-cycle read latency.
    always @(posedge clk) begin
        if (win_mem_rd_en) win_mem_rd_data <= 32'(win_mem_rd_addr);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rev(input int v, input int n);
        int l = 0;
        int r = 0;
        while ((1 << l) < n) l++;
        for (int i = 0; i < l; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    task automatic idle_outputs(input string tag);
        chk({tag, " rd_en"}, 64'(win_mem_rd_en), 64'd0);
        chk({tag, " valid"}, 64'(fft_valid), 64'd0);
        chk({tag, " data"},  64'(fft_data), 64'd0);
        chk({tag, " index"}, 64'(fft_index), 64'd0);
        chk({tag, " last"},  64'(fft_last), 64'd0);
        chk({tag, " busy"},  64'(reader_busy), 64'd0);
        chk({tag, " done"},  64'(reader_done), 64'd0);
        chk({tag, " cfg"},   64'(cfg_err), 64'd0);
    endtask

    task automatic run_frame(input int n, input bit br, input bit rnd, input string tag);
        int hs = 0;
        int issued = 0;
        int dones = 0;
        int cyc = 0;
        int e;
        @(negedge clk);
        fft_num = 12'(n); bitrev_en = br; reader_en = 1'b1; fft_ready = 1'b1;
        @(negedge clk);
        reader_en = 1'b0;
        fft_num = 12'd16; bitrev_en = ~br;   // mid-frame changes must be ignored
        while (dones == 0 && cyc < 20000) begin
            if (rnd) fft_ready = 1'($urandom_range(0, 1));
            chk({tag, " outstanding"}, 64'((issued - hs) <= 4), 64'd1);
            if (win_mem_rd_en) issued++;
            if (fft_valid && fft_ready) begin
                e = br ? rev(hs, n) : hs;
                chk({tag, " data"},  64'(fft_data), 64'(e));
                chk({tag, " index"}, 64'(fft_index), 64'(hs));
                chk({tag, " last"},  64'(fft_last), 64'(hs == n - 1));
                hs++;
            end
            if (reader_done) begin
                dones++;
                chk({tag, " busy at done"}, 64'(reader_busy), 64'd0);
            end
            cyc++;
            @(negedge clk);
        end
        fft_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (reader_done) dones++;
            @(negedge clk);
        end
        chk({tag, " timeout"},   64'(cyc < 20000), 64'd1);
        chk({tag, " handshakes"}, 64'(hs), 64'(n));
        chk({tag, " reads"},     64'(issued), 64'(n));
        chk({tag, " done count"}, 64'(dones), 64'd1);
    endtask

    initial begin
        logic [12:0] bad [4];
        int hs;
        int cyc;
        bad[0] = 13'd100; bad[1] = 13'd0; bad[2] = 13'd4096; bad[3] = 13'd4;

        // Reset state
        @(negedge clk);
        idle_outputs("reset");
        rst = 1'b0;

        // N=8 natural order, exact cycle timing
        @(negedge clk);
        fft_num = 12'd8; bitrev_en = 1'b0; fft_ready = 1'b1; reader_en = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            reader_en = 1'b0;
            chk($sformatf("n8 c%0d rd_en", c), 64'(win_mem_rd_en), 64'(c >= 1 && c <= 8));
            if (c >= 1 && c <= 8)
                chk($sformatf("n8 c%0d addr", c), 64'(win_mem_rd_addr), 64'(c - 1));
            chk($sformatf("n8 c%0d valid", c), 64'(fft_valid), 64'(c >= 3 && c <= 10));
            chk($sformatf("n8 c%0d data", c), 64'(fft_data), (c >= 3 && c <= 10) ? 64'(c - 3) : 64'd0);
            chk($sformatf("n8 c%0d index", c), 64'(fft_index), (c >= 3 && c <= 10) ? 64'(c - 3) : 64'd0);
            chk($sformatf("n8 c%0d last", c), 64'(fft_last), 64'(c == 10));
            chk($sformatf("n8 c%0d done", c), 64'(reader_done), 64'(c == 11));
            chk($sformatf("n8 c%0d busy", c), 64'(reader_busy), 64'(c >= 1 && c <= 10));
            if (c == 11) reader_en = 1'b1;   // start in DONE cycle is ignored
        end

        // Bit-reversed order, N=8
        run_frame(8, 1'b1, 1'b0, "n8 bitrev");

        // Illegal lengths
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            fft_num = bad[i][11:0]; reader_en = 1'b1;
            @(negedge clk);
            reader_en = 1'b0;
            chk($sformatf("bad%0d cfg pulse", i), 64'(cfg_err), 64'd1);
            chk($sformatf("bad%0d busy", i), 64'(reader_busy), 64'd0);
            chk($sformatf("bad%0d rd_en", i), 64'(win_mem_rd_en), 64'd0);
            @(negedge clk);
            chk($sformatf("bad%0d cfg clear", i), 64'(cfg_err), 64'd0);
            chk($sformatf("bad%0d busy2", i), 64'(reader_busy), 64'd0);
            chk($sformatf("bad%0d rd_en2", i), 64'(win_mem_rd_en), 64'd0);
        end

        // Largest frame under random backpressure
        run_frame(2048, 1'b0, 1'b1, "n2048");

        // Mid-frame reset at handshake 20
        @(negedge clk);
        fft_num = 12'd64; bitrev_en = 1'b0; fft_ready = 1'b1; reader_en = 1'b1;
        @(negedge clk);
        reader_en = 1'b0;
        hs = 0; cyc = 0;
        while (hs < 20 && cyc < 1000) begin
            if (fft_valid && fft_ready) begin
                chk("abort data", 64'(fft_data), 64'(hs));
                hs++;
            end
            cyc++;
            @(negedge clk);
        end
        chk("abort timeout", 64'(cyc < 1000), 64'd1);
        rst = 1'b1;
        #1;
        idle_outputs("abort rst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_outputs($sformatf("post rst %0d", i));
        end
        run_frame(64, 1'b0, 1'b0, "restart n64");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
